// File: rtl/cic3_row_pkg.sv
// Shared sizing, FSM state type and flat-bus word extraction for the CIC3 row readout.
package cic3_row_pkg;

    localparam int unsigned NUM_CH = 24;
    localparam int unsigned DATA_W = 25;
    localparam int unsigned CH_W   = 5;
    localparam int unsigned FCNT_W = 8;
    localparam int unsigned FLAT_W = NUM_CH * DATA_W;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Word k of the concatenated filter bus (channel 0 in the LSBs).
    function automatic logic [DATA_W-1:0] get_word(input logic [FLAT_W-1:0] flat,
                                                   input logic [CH_W-1:0]   k);
        return flat[int'(k)*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/cic3_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit, found flag, and the mask with that bit cleared.
module cic3_prio_enc
    import cic3_row_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    output logic [CH_W-1:0]   lowest_idx_c,
    output logic              found_c,
    output logic [NUM_CH-1:0] mask_clr_c
);

    always_comb begin
        lowest_idx_c = '0;
        found_c      = 1'b0;
        // Scan high to low so the lowest set bit is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                lowest_idx_c = CH_W'(i);
                found_c      = 1'b1;
            end
        end
        mask_clr_c = mask_i & (mask_i - NUM_CH'(1));
    end

endmodule

// File: rtl/cic3_row_readout_sched.sv
// Readout scheduler for the 24-channel CIC3 row: snapshot on strobe, drain enabled
// channels lowest-index first over valid/ready, flag strobes dropped while draining.
module cic3_row_readout_sched
    import cic3_row_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_strobe,
    input  logic [NUM_CH*DATA_W-1:0] filt_data,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     clr_overrun,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_sof,
    output logic                     out_eof,
    output logic [FCNT_W-1:0]        out_frame,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     overrun
);

    state_e              state_q, state_d;
    logic [FLAT_W-1:0]   snap_q,  snap_d;
    logic [NUM_CH-1:0]   pend_q,  pend_d;
    logic [FCNT_W-1:0]   frame_q, frame_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [CH_W-1:0]     ch_q,    ch_d;
    logic                sof_q,   sof_d;
    logic                eof_q,   eof_d;
    logic                valid_q, valid_d;
    logic                busy_q,  busy_d;
    logic                ovr_q,   ovr_d;

    logic [CH_W-1:0]     cur_idx,   nxt_idx;
    logic                cur_found, nxt_found;
    logic [NUM_CH-1:0]   cur_clr,   nxt_clr;
    logic [NUM_CH-1:0]   nxt_mask;

    logic                hs;
    logic                last_hs;
    logic                capture;
    logic                ovr_set;

    // Encoder on the live pending mask: the word currently presented.
    cic3_prio_enc u_enc_cur (
        .mask_i       (pend_q),
        .lowest_idx_c (cur_idx),
        .found_c      (cur_found),
        .mask_clr_c   (cur_clr)
    );

    // Encoder on the mask that will be live next cycle (fresh enable on capture).
    cic3_prio_enc u_enc_nxt (
        .mask_i       (nxt_mask),
        .lowest_idx_c (nxt_idx),
        .found_c      (nxt_found),
        .mask_clr_c   (nxt_clr)
    );

    assign hs       = valid_q && out_ready;
    assign last_hs  = hs && cur_found && (cur_clr == '0);
    assign capture  = sample_strobe && (ch_enable != '0) && ((state_q == IDLE) || last_hs);
    assign ovr_set  = sample_strobe && (state_q == DRAIN) && !last_hs;
    assign nxt_mask = capture ? ch_enable : (hs ? cur_clr : pend_q);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        pend_d  = pend_q;
        frame_d = frame_q;
        data_d  = data_q;
        ch_d    = ch_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;

        if (capture) begin
            // New frame: first word comes straight from the bus being snapshotted.
            state_d = DRAIN;
            snap_d  = filt_data;
            pend_d  = ch_enable;
            frame_d = frame_q + FCNT_W'(1);
            ch_d    = nxt_idx;
            data_d  = get_word(filt_data, nxt_idx);
            sof_d   = 1'b1;
            eof_d   = (nxt_clr == '0);
            valid_d = 1'b1;
            busy_d  = 1'b1;
        end else if (state_q == DRAIN) begin
            if (hs) begin
                pend_d = cur_clr;
                if (nxt_found) begin
                    ch_d   = nxt_idx;
                    data_d = get_word(snap_q, nxt_idx);
                    sof_d  = 1'b0;
                    eof_d  = (nxt_clr == '0);
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    sof_d   = 1'b0;
                    eof_d   = 1'b0;
                end
            end else begin
                ch_d   = cur_idx;
                data_d = get_word(snap_q, cur_idx);
            end
        end

        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clr_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            pend_q  <= '0;
            frame_q <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            pend_q  <= pend_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_sof   = sof_q;
    assign out_eof   = eof_q;
    assign out_frame = frame_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_cic3_row_readout_sched.sv
// Scoreboard bench for cic3_row_readout_sched: a frame-level model queues expected
// words on each accepted strobe; a negedge monitor compares whatever the DUT presents.
module tb_cic3_row_readout_sched;
    import cic3_row_pkg::*;

    typedef struct {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eof;
        logic [FCNT_W-1:0] frame;
    } word_t;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     sample_strobe = 1'b0;
    logic [NUM_CH*DATA_W-1:0] filt_data = '0;
    logic [NUM_CH-1:0]        ch_enable = '0;
    logic                     clr_overrun = 1'b0;
    logic                     out_ready = 1'b0;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_sof;
    logic                     out_eof;
    logic [FCNT_W-1:0]        out_frame;
    logic                     out_valid;
    logic                     busy;
    logic                     overrun;

    int n_cmp = 0;
    int n_bad = 0;

    word_t             exp_q[$];
    int                rd_idx = 0;
    int                wrap_seen = 0;
    int                m_rem = 0;
    logic [FCNT_W-1:0] m_frame = '0;
    logic              m_ovr = 1'b0;

    int    mr0, mcnt, midx;
    bit    mhs, mwin;
    word_t mw, mon_w;

    always #5 clk = ~clk;

    cic3_row_readout_sched dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_strobe (sample_strobe),
        .filt_data     (filt_data),
        .ch_enable     (ch_enable),
        .clr_overrun   (clr_overrun),
        .out_data      (out_data),
        .out_ch        (out_ch),
        .out_sof       (out_sof),
        .out_eof       (out_eof),
        .out_frame     (out_frame),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .overrun       (overrun)
    );

    // Reference model: words left in the frame, frame number, overrun flag.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_rem   = 0;
            m_frame = '0;
            m_ovr   = 1'b0;
        end else begin
            mr0  = m_rem;
            mhs  = (mr0 > 0) && out_ready;
            if (mhs) m_rem = m_rem - 1;
            mwin = (mr0 == 0) || (mhs && mr0 == 1);
            if (sample_strobe && mwin && ch_enable != '0) begin
                m_frame = m_frame + FCNT_W'(1);
                mcnt = 0;
                for (int k = 0; k < NUM_CH; k++) if (ch_enable[k]) mcnt++;
                midx = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (ch_enable[k]) begin
                        mw.ch    = CH_W'(k);
                        mw.data  = filt_data[k*DATA_W +: DATA_W];
                        mw.sof   = (midx == 0);
                        mw.eof   = (midx == mcnt - 1);
                        mw.frame = m_frame;
                        exp_q.push_back(mw);
                        midx++;
                    end
                end
                m_rem = mcnt;
            end
            if (sample_strobe && !mwin) m_ovr = 1'b1;
            else if (clr_overrun) m_ovr = 1'b0;
        end
    end

    // Monitor: control flags every cycle, presented word against the queue head.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            rd_idx = exp_q.size();
        end else begin
            n_cmp++;
            if (out_valid !== (m_rem > 0) || busy !== (m_rem > 0) || overrun !== m_ovr) begin
                n_bad++;
                $display("FAIL ctrl t=%0t got valid=%b busy=%b ovr=%b need valid=busy=%0b ovr=%b",
                         $time, out_valid, busy, overrun, (m_rem > 0), m_ovr);
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (rd_idx >= exp_q.size()) begin
                    n_bad++;
                    $display("FAIL extra_word t=%0t got ch=%0d data=%h with nothing expected",
                             $time, out_ch, out_data);
                end else begin
                    mon_w = exp_q[rd_idx];
                    if (out_ch !== mon_w.ch || out_data !== mon_w.data || out_sof !== mon_w.sof ||
                        out_eof !== mon_w.eof || out_frame !== mon_w.frame) begin
                        n_bad++;
                        $display("FAIL word t=%0t got ch=%0d data=%h sof=%b eof=%b fr=%0d need ch=%0d data=%h sof=%b eof=%b fr=%0d",
                                 $time, out_ch, out_data, out_sof, out_eof, out_frame,
                                 mon_w.ch, mon_w.data, mon_w.sof, mon_w.eof, mon_w.frame);
                    end
                end
                if (out_frame == '0) wrap_seen++;
                if (out_ready) rd_idx++;
            end
        end
    end

    task automatic step(input logic stb, input logic [NUM_CH-1:0] en, input logic rdy, input logic clr);
        sample_strobe = stb;
        ch_enable     = en;
        out_ready     = rdy;
        clr_overrun   = clr;
        @(posedge clk);
        #1;
        sample_strobe = 1'b0;
        clr_overrun   = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(1'b0, ch_enable, rdy, 1'b0);
    endtask

    task automatic wait_rem(input int target, input logic rdy);
        int c = 0;
        while (m_rem != target && c < 200) begin
            step(1'b0, ch_enable, rdy, 1'b0);
            c++;
        end
        n_cmp++;
        if (m_rem != target) begin
            n_bad++;
            $display("FAIL wait_timeout got remaining=%0d need %0d", m_rem, target);
        end
    endtask

    task automatic chk_zero(input string name);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_sof !== 1'b0 ||
            out_eof !== 1'b0 || out_data !== '0 || out_ch !== '0 || out_frame !== '0) begin
            n_bad++;
            $display("FAIL %s got v=%b b=%b o=%b sof=%b eof=%b d=%h ch=%0d fr=%0d need all 0",
                     name, out_valid, busy, overrun, out_sof, out_eof, out_data, out_ch, out_frame);
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < NUM_CH; k++) filt_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    initial begin
        logic [NUM_CH-1:0] ren;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        reset_n = 1'b1;

        // Full row, fixed pattern, always ready.
        for (int k = 0; k < NUM_CH; k++) filt_data[k*DATA_W +: DATA_W] = DATA_W'(k + 'h100);
        step(1'b1, 24'hFFFFFF, 1'b1, 1'b0);
        idle(30, 1'b1);

        // Sparse mask with ready toggling.
        rand_data();
        step(1'b1, 24'h800005, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, ch_enable, logic'(i % 2), 1'b0);
        idle(4, 1'b1);

        // Dropped strobe with three words left, then clear, then set+clear together.
        rand_data();
        step(1'b1, 24'hFFFFFF, 1'b1, 1'b0);
        wait_rem(3, 1'b1);
        rand_data();
        step(1'b1, 24'h0F0F0F, 1'b1, 1'b0);
        wait_rem(0, 1'b1);
        step(1'b0, ch_enable, 1'b1, 1'b1);
        idle(2, 1'b1);
        rand_data();
        step(1'b1, 24'h00FF00, 1'b1, 1'b0);
        idle(2, 1'b1);
        step(1'b1, 24'h000001, 1'b1, 1'b1);
        wait_rem(0, 1'b1);
        step(1'b0, ch_enable, 1'b1, 1'b1);

        // Strobe on the eof handshake, then an empty-mask strobe.
        rand_data();
        step(1'b1, 24'h000003, 1'b1, 1'b0);
        wait_rem(1, 1'b1);
        rand_data();
        step(1'b1, 24'h0000F0, 1'b1, 1'b0);
        wait_rem(0, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 24'h000000, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_data();
            case ($urandom % 4)
                0: ren = '0;
                1: ren = NUM_CH'(1) << ($urandom % NUM_CH);
                default: ren = NUM_CH'($urandom);
            endcase
            step(logic'(($urandom % 6) == 0), ren, logic'(($urandom % 3) != 0),
                 logic'(($urandom % 10) == 0));
        end
        wait_rem(0, 1'b1);
        step(1'b0, ch_enable, 1'b1, 1'b1);

        // Asynchronous reset mid-frame while stalled.
        rand_data();
        step(1'b1, 24'hFFFFFF, 1'b1, 1'b0);
        idle(4, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        rand_data();
        step(1'b1, 24'h000408, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Frame counter wrap.
        for (int i = 0; i < 256; i++) begin
            rand_data();
            step(1'b1, NUM_CH'(1) << ($urandom % NUM_CH), 1'b1, 1'b0);
            step(1'b0, ch_enable, 1'b1, 1'b0);
        end
        idle(3, 1'b1);

        n_cmp++;
        if (rd_idx != exp_q.size()) begin
            n_bad++;
            $display("FAIL drained got %0d words consumed need %0d", rd_idx, exp_q.size());
        end
        n_cmp++;
        if (wrap_seen == 0) begin
            n_bad++;
            $display("FAIL frame_wrap got no word with frame 0 need at least 1");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
